hex_display_monitor: RTL and testbench

//  Receive-side checker for the counter/seven-segment display path. Samples six active-low
//  HEX digit buses and decodes them back into a hex count value. Checks that every new

---
 rtl/hex_display_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_hex_display_monitor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_monitor.sv
// ---------------------------------------------------------------------------
// hex_display_monitor
//
// Receive-side checker for a counter driving six seven-segment displays.
// It samples the active-low HEX digit buses and decodes them back into a hex
// count. A word is used only after it has stayed unchanged for long enough
// (debounce). It then checks that each new accepted count is exactly one step
// (+1 or -1, modulo 2^(4*DIGITS)) away from the previous one.
//
// Parameters
//   DIGITS      number of seven-segment digits observed (value is 4*DIGITS bits)
//   STABLE_CYC  identical consecutive samples needed before a word is accepted
//   ERRCNT_W    width of the saturating error counter
//
// Ports
//   MAX10_CLK1_50  in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   enable         in   1 = monitoring, 0 = idle (value held, locked dropped)
//   up             in   expected count direction: 1 = +1, 0 = -1
//   hex_in         in   digit i at [8i+7:8i], active-low, bit 7 = decimal point
//   value          out  last accepted decoded count, digit i at [4i+3:4i]
//   locked         out  a reference count has been acquired
//   step_pulse     out  one cycle: accepted word is the legal next step
//   step_err       out  one cycle: accepted word is neither the current value
//                       nor the legal next step (value resyncs to it)
//   bad_seg        out  one cycle: accepted word holds an undecodable digit
//   err_count      out  count of step_err + bad_seg events, saturating
//
// Optional feature (macro HEX_ERRLOG_EN):
//   exp_last, obs_last  out  expected step value and observed word captured
//                            on the most recent step_err
// ---------------------------------------------------------------------------
module hex_display_monitor #(
    parameter int DIGITS     = 6,
    parameter int STABLE_CYC = 4,
    parameter int ERRCNT_W   = 8
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic [8*DIGITS-1:0]   hex_in,
    output logic [4*DIGITS-1:0]   value,
    output logic                  locked,
    output logic                  step_pulse,
    output logic                  step_err,
    output logic                  bad_seg,
    output logic [ERRCNT_W-1:0]   err_count
`ifdef HEX_ERRLOG_EN
    ,
    output logic [4*DIGITS-1:0]   exp_last,
    output logic [4*DIGITS-1:0]   obs_last
`endif
);

    localparam int VAL_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    // The counter value that marks "held for STABLE_CYC samples" and the
    // value it parks at afterwards so the same word is never accepted twice.
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(STABLE_CYC);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] TRACK   = 2'd2;

    // Returns {valid, nibble}. Only the seven segment bits are examined, so the
    // decimal point never affects decoding. Blank and any other shape is invalid.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] d;
        case (seg)
            7'h40:   d = 5'h10;
            7'h79:   d = 5'h11;
            7'h24:   d = 5'h12;
            7'h30:   d = 5'h13;
            7'h19:   d = 5'h14;
            7'h12:   d = 5'h15;
            7'h02:   d = 5'h16;
            7'h78:   d = 5'h17;
            7'h00:   d = 5'h18;
            7'h10:   d = 5'h19;
            7'h08:   d = 5'h1A;
            7'h03:   d = 5'h1B;
            7'h46:   d = 5'h1C;
            7'h21:   d = 5'h1D;
            7'h06:   d = 5'h1E;
            7'h0E:   d = 5'h1F;
            default: d = 5'h00;
        endcase
        return d;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [1:0]          state;
    logic [8*DIGITS-1:0] hex_q;
    logic [CNT_W-1:0]    stab_cnt;

    logic [4:0]          dig;
    logic [VAL_W-1:0]    word_val;
    logic                word_ok;
    logic [VAL_W-1:0]    step_val;
    logic                accept;
    logic                is_same;
    logic                is_step;
    logic                is_resync;

    // ---- stage p0: input sampling and stability filter ----
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            hex_q    <= '1;
            stab_cnt <= '0;
        end else begin
            hex_q <= hex_in;
            // Entering ACQUIRE restarts the stability window so a word that
            // was sitting on the bus while idle still needs a full hold.
            if (state == IDLE && enable) begin
                stab_cnt <= '0;
            end else if (hex_in != hex_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CNT_SAT) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // Decode of the filtered word and classification against the reference.
    always_comb begin
        dig      = '0;
        word_val = '0;
        word_ok  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig                = seg_decode(hex_q[8*i +: 7]);
            word_val[4*i +: 4] = dig[3:0];
            word_ok            = word_ok & dig[4];
        end
    end

    // Width-limited add/subtract gives the modulo wrap (FF..F+1 = 0, 0-1 = FF..F).
    assign step_val  = up ? value + 1'b1 : value - 1'b1;

    // The accepted word is the one that has been in hex_q for STABLE_CYC
    // samples; what appears on hex_in at the accepting edge does not matter.
    assign accept    = enable && (state != IDLE) && (stab_cnt == CNT_ACCEPT);
    assign is_same   = (word_val == value);
    assign is_step   = !is_same && (word_val == step_val);
    assign is_resync = accept && (state == TRACK) && word_ok && !is_same && !is_step;

    // ---- stage p1: FSM, reference value and event outputs ----
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            value      <= '0;
            locked     <= 1'b0;
            step_pulse <= 1'b0;
            step_err   <= 1'b0;
            bad_seg    <= 1'b0;
            err_count  <= '0;
        end else begin
            step_pulse <= 1'b0;
            step_err   <= 1'b0;
            bad_seg    <= 1'b0;
            if (!enable) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (accept) begin
                            if (word_ok) begin
                                value  <= word_val;
                                locked <= 1'b1;
                                state  <= TRACK;
                            end else begin
                                bad_seg   <= 1'b1;
                                err_count <= sat_inc(err_count);
                            end
                        end
                    end
                    TRACK: begin
                        if (accept) begin
                            if (!word_ok) begin
                                bad_seg   <= 1'b1;
                                err_count <= sat_inc(err_count);
                            end else if (is_step) begin
                                step_pulse <= 1'b1;
                                value      <= word_val;
                            end else if (is_resync) begin
                                step_err   <= 1'b1;
                                err_count  <= sat_inc(err_count);
                                value      <= word_val;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef HEX_ERRLOG_EN
    // ---- stage p1: last-error capture ----
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            exp_last <= '0;
            obs_last <= '0;
        end else if (is_resync) begin
            exp_last <= step_val;
            obs_last <= word_val;
        end
    end
`endif

endmodule

// File: tb/tb_hex_display_monitor.sv
module tb_hex_display_monitor;

    localparam int DIGITS = 6;
    localparam int S      = 4;
    localparam int EW     = 8;
    localparam int VW     = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          up;
    logic [47:0]   hex_in;
    logic [VW-1:0] value;
    logic          locked;
    logic          step_pulse;
    logic          step_err;
    logic          bad_seg;
    logic [EW-1:0] err_count;
`ifdef HEX_ERRLOG_EN
    logic [VW-1:0] exp_last;
    logic [VW-1:0] obs_last;
`endif

    always #10 clk = ~clk;

    hex_display_monitor #(.DIGITS(DIGITS), .STABLE_CYC(S), .ERRCNT_W(EW)) dut (
        .MAX10_CLK1_50(clk),
        .reset(reset),
        .enable(enable),
        .up(up),
        .hex_in(hex_in),
        .value(value),
        .locked(locked),
        .step_pulse(step_pulse),
        .step_err(step_err),
        .bad_seg(bad_seg),
        .err_count(err_count)
`ifdef HEX_ERRLOG_EN
        ,
        .exp_last(exp_last),
        .obs_last(obs_last)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Active-low segment shapes for 0..F, decimal point excluded.
    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [47:0] enc(input logic [23:0] v, input logic dp_on);
        logic [47:0] h;
        logic [3:0]  nib;
        h = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib          = v[4*i +: 4];
            h[8*i +: 8]  = {~dp_on, seg_lut[nib]};
        end
        return h;
    endfunction

    function automatic bit m_decode(input logic [47:0] h, output logic [23:0] v);
        bit found;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            found = 0;
            for (int d = 0; d < 16; d++) begin
                if (h[8*i +: 7] == seg_lut[d]) begin
                    v[4*i +: 4] = 4'(d);
                    found       = 1;
                end
            end
            if (!found) return 0;
        end
        return 1;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (edge-indexed) ----------------
    int          n_edge = 0;
    int          run_start;   // edge at which the current stability window began
    int          mstate;      // 0 idle, 1 acquire, 2 track
    logic [47:0] m_hexq;
    logic [23:0] m_value, m_exp, m_obs;
    bit          m_locked, m_sp, m_se, m_bad;
    int          m_err;

    task automatic model_reset();
        m_hexq    = '1;
        run_start = n_edge;
        mstate    = 0;
        m_value   = '0;
        m_exp     = '0;
        m_obs     = '0;
        m_locked  = 0;
        m_sp      = 0;
        m_se      = 0;
        m_bad     = 0;
        m_err     = 0;
    endtask

    task automatic bump_err();
        if (m_err < (1 << EW) - 1) m_err++;
    endtask

    task automatic model_step();
        bit          acc, ok;
        logic [47:0] w;
        logic [23:0] dv, nxt;
        n_edge++;
        m_sp  = 0;
        m_se  = 0;
        m_bad = 0;
        acc   = enable && (mstate != 0) && (n_edge - run_start == S);
        w     = m_hexq;
        if (hex_in != m_hexq) begin
            m_hexq    = hex_in;
            run_start = n_edge;
        end
        if (!enable) begin
            mstate   = 0;
            m_locked = 0;
        end else if (mstate == 0) begin
            mstate    = 1;
            run_start = n_edge;
        end else if (acc) begin
            ok = m_decode(w, dv);
            if (!ok) begin
                m_bad = 1;
                bump_err();
            end else if (mstate == 1) begin
                m_value  = dv;
                m_locked = 1;
                mstate   = 2;
            end else begin
                nxt = up ? 24'(m_value + 24'd1) : 24'(m_value - 24'd1);
                if (dv == m_value) begin
                end else if (dv == nxt) begin
                    m_sp    = 1;
                    m_value = dv;
                end else begin
                    m_se    = 1;
                    bump_err();
                    m_exp   = nxt;
                    m_obs   = dv;
                    m_value = dv;
                end
            end
        end
    endtask

    int cnt_p, cnt_s, cnt_b;

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle_state", {value, locked, step_pulse, step_err, bad_seg, err_count},
              {m_value, m_locked, m_sp, m_se, m_bad, 8'(m_err)});
`ifdef HEX_ERRLOG_EN
        check("cycle_errlog", {exp_last, obs_last}, {m_exp, m_obs});
`endif
        cnt_p += int'(step_pulse);
        cnt_s += int'(step_err);
        cnt_b += int'(bad_seg);
    endtask

    task automatic hold(input logic [47:0] h, input int n);
        hex_in = h;
        for (int c = 0; c < n; c++) cycle();
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic reset_mid();
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("reset_async", {value, locked, step_pulse, step_err, bad_seg, err_count}, '0);
`ifdef HEX_ERRLOG_EN
        check("reset_errlog", {exp_last, obs_last}, '0);
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [47:0] hex;
        int          hold;
        logic        up;
        logic [23:0] e_value;
        logic        e_locked;
        int          e_err;
        int          e_pulse;
        int          e_serr;
        int          e_bad;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [47:0] h, input int hd, input logic u, input logic [23:0] v,
                       input logic l, input int e, input int p, input int s, input int b);
        vec_t r;
        r.hex = h; r.hold = hd; r.up = u; r.e_value = v; r.e_locked = l;
        r.e_err = e; r.e_pulse = p; r.e_serr = s; r.e_bad = b;
        tv.push_back(r);
    endtask

    initial begin
        logic [47:0] bad9, h;
        logic [23:0] base;
        int          kind, j;

        reset  = 1'b1;
        enable = 1'b0;
        up     = 1'b1;
        hex_in = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("reset_state", {value, locked, step_pulse, step_err, bad_seg, err_count}, '0);

        bad9            = enc(24'h000009, 1'b0);
        bad9[8*2 +: 8]  = 8'hFF;

        //   word                        hold up value        lk err pul serr bad
        add(enc(24'h000000, 0),          6, 1, 24'h000000, 1, 0, 0, 0, 0);
        add(enc(24'h000001, 0),          6, 1, 24'h000001, 1, 0, 1, 0, 0);
        add(enc(24'h000002, 0),          6, 1, 24'h000002, 1, 0, 1, 0, 0);
        add(enc(24'h000003, 0),          6, 1, 24'h000003, 1, 0, 1, 0, 0);
        add(enc(24'h000004, 0),          6, 1, 24'h000004, 1, 0, 1, 0, 0);
        add(enc(24'h000005, 0),          6, 1, 24'h000005, 1, 0, 1, 0, 0);
        add(enc(24'h000009, 0),          6, 1, 24'h000009, 1, 1, 0, 1, 0);
        add(bad9,                        6, 1, 24'h000009, 1, 2, 0, 0, 1);
        add(enc(24'h000009, 0),          6, 1, 24'h000009, 1, 2, 0, 0, 0);
        add(enc(24'h000007, 0),          2, 1, 24'h000009, 1, 2, 0, 0, 0);
        add(enc(24'h000009, 0),          6, 1, 24'h000009, 1, 2, 0, 0, 0);
        add(enc(24'h000008, 0),          6, 0, 24'h000008, 1, 2, 1, 0, 0);
        add(enc(24'h000000, 0),          6, 0, 24'h000000, 1, 3, 0, 1, 0);
        add(enc(24'hFFFFFF, 0),          6, 0, 24'hFFFFFF, 1, 3, 1, 0, 0);
        add(enc(24'h000000, 0),          6, 1, 24'h000000, 1, 3, 1, 0, 0);
        add(enc(24'h000001, 1),          6, 1, 24'h000001, 1, 3, 1, 0, 0);

        enable = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            cnt_p = 0; cnt_s = 0; cnt_b = 0;
            up = tv[i].up;
            hold(tv[i].hex, tv[i].hold);
            check($sformatf("vec%0d_value", i), value, tv[i].e_value);
            check($sformatf("vec%0d_locked", i), locked, tv[i].e_locked);
            check($sformatf("vec%0d_errcnt", i), err_count, tv[i].e_err);
            check($sformatf("vec%0d_events", i), {cnt_p, cnt_s, cnt_b},
                  {tv[i].e_pulse, tv[i].e_serr, tv[i].e_bad});
`ifdef HEX_ERRLOG_EN
            if (i == 6) check("vec6_errlog", {exp_last, obs_last}, {24'h000006, 24'h000009});
`endif
        end

        // Disable drops lock but holds value; re-enable reacquires without a pulse.
        enable = 1'b0;
        cycle();
        cycle();
        check("disable_locked", {locked, value}, {1'b0, 24'h000001});
        enable = 1'b1;
        cnt_p = 0; cnt_s = 0; cnt_b = 0;
        hold(enc(24'h000001, 0), 6);
        check("reacquire", {locked, value, 8'(cnt_p + cnt_s + cnt_b)}, {1'b1, 24'h000001, 8'd0});

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 5);
            up   = 1'($urandom_range(0, 1));
            base = m_value;
            case (kind)
                0: h = enc(24'(base + 24'd1), 1'($urandom_range(0, 1)));
                1: h = enc(24'(base - 24'd1), 1'($urandom_range(0, 1)));
                2: h = enc(base, 1'b0);
                3: h = enc(24'($urandom), 1'b0);
                4: begin
                    h = enc(24'($urandom), 1'b0);
                    j = $urandom_range(0, DIGITS - 1);
                    h[8*j +: 8] = 8'hFF;
                end
                default: h = hex_in;
            endcase
            enable = (kind != 5);
            hold(h, $urandom_range(1, 7));
        end
        enable = 1'b1;

        // Reset between edges while tracking.
        reset_mid();
        up = 1'b1;
        hold(enc(24'h123456, 0), 6);
        check("track_before_reset", {locked, value}, {1'b1, 24'h123456});
        reset_mid();

        // Drive the error counter into saturation.
        for (int k = 0; k < 260; k++) hold(enc((k % 2) ? 24'h800000 : 24'h000000, 0), 5);
        check("errcnt_sat", err_count, 8'hFF);
        cnt_s = 0;
        hold(enc(24'h123456, 0), 6);
        check("errcnt_hold", {err_count, 8'(cnt_s)}, {8'hFF, 8'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
